// File: rtl/aes_pkg.sv
// Shared AES-128 types, round constants and key-schedule FSM states.
// Blocks are byte arrays: byte 0 is the most significant byte of the vector.
package aes_pkg;

    typedef logic [7:0] byte_t;
    typedef byte_t [0:15] block_t;

    localparam int NUM_ROUNDS = 10;
    localparam logic [3:0] LAST_ROUND = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_READY
    } state_t;

    function automatic byte_t rcon(input logic [3:0] i_round);
        byte_t w_rc;
        case (i_round)
            4'd1:    w_rc = 8'h01;
            4'd2:    w_rc = 8'h02;
            4'd3:    w_rc = 8'h04;
            4'd4:    w_rc = 8'h08;
            4'd5:    w_rc = 8'h10;
            4'd6:    w_rc = 8'h20;
            4'd7:    w_rc = 8'h40;
            4'd8:    w_rc = 8'h80;
            4'd9:    w_rc = 8'h1b;
            4'd10:   w_rc = 8'h36;
            default: w_rc = 8'h00;
        endcase
        return w_rc;
    endfunction

endpackage

// File: rtl/sbox.sv
// Forward AES S-box, purely combinational table lookup.
// Entry 0 sits in the top byte of the table vector.
module sbox (
    input  logic [7:0] i_in,
    output logic [7:0] o_out
);

    localparam logic [2047:0] TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // (255 - i_in) * 8 without arithmetic: invert and shift
    assign o_out = TABLE[{~i_in, 3'b000} +: 8];

endmodule

// File: rtl/key_schedule.sv
// AES-128 key expansion: one round key per cycle into an 11-entry store.
// key_ready asserts one cycle after the last round key lands.
module key_schedule
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  block_t     key_in,
    output logic       busy,
    output logic       key_ready,
    input  logic [3:0] rd_round,
    output block_t     rd_key
);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic        r_key_ready;
    block_t      r_rk [0:NUM_ROUNDS];

    logic [3:0]   w_prev_idx;
    logic [127:0] w_prev;
    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [31:0]  w_n0, w_n1, w_n2, w_n3;
    block_t       w_next;

    assign w_prev_idx = r_cnt - 4'd1;
    assign w_prev     = r_rk[w_prev_idx];

    assign w_w0 = w_prev[127:96];
    assign w_w1 = w_prev[95:64];
    assign w_w2 = w_prev[63:32];
    assign w_w3 = w_prev[31:0];

    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sub
        sbox u_sbox (
            .i_in  (w_rot[31-8*g -: 8]),
            .o_out (w_sub[31-8*g -: 8])
        );
    end

    assign w_n0   = w_w0 ^ w_sub ^ {rcon(r_cnt), 24'h000000};
    assign w_n1   = w_w1 ^ w_n0;
    assign w_n2   = w_w2 ^ w_n1;
    assign w_n3   = w_w3 ^ w_n2;
    assign w_next = {w_n0, w_n1, w_n2, w_n3};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_busy      <= 1'b0;
            r_key_ready <= 1'b0;
            for (int k = 0; k <= NUM_ROUNDS; k++) begin
                r_rk[k] <= '0;
            end
        end else begin
            unique case (r_state)
                ST_IDLE, ST_READY: begin
                    if (start) begin
                        r_rk[0]     <= key_in;
                        r_cnt       <= 4'd1;
                        r_state     <= ST_EXPAND;
                        r_busy      <= 1'b1;
                        r_key_ready <= 1'b0;
                    end else if (r_state == ST_READY) begin
                        r_key_ready <= 1'b1;
                    end
                end
                ST_EXPAND: begin
                    r_rk[r_cnt] <= w_next;
                    if (r_cnt == LAST_ROUND) begin
                        r_state <= ST_READY;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign key_ready = r_key_ready;

    always_comb begin
        rd_key = '0;
        if (rd_round <= LAST_ROUND) begin
            rd_key = r_rk[rd_round];
        end
    end

endmodule

// File: doc/key_schedule.md
KEY_SCHEDULE -- requirements
Module: key_schedule

Interface
REQ-001 Parameters: none; AES-128 only (Nk=4, Nr=10).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  one-cycle request to expand key_in; sampled only in IDLE or READY.
REQ-005 key_in  input  8 x 16 (byte array [0:15])  cipher key; byte 0 first; bytes 4c..4c+3 form column c.
REQ-006 busy  output  1  high while expansion is in progress.
REQ-007 key_ready  output  1  high when all 11 round keys are valid.
REQ-008 rd_round  input  4  round-key index 0..10.
REQ-009 rd_key  output  8 x 16 (byte array [0:15])  round key rd_round, same byte/column order as key_in; consumed by add_round_key after the mix-column stage.

Function
REQ-010 FSM states: IDLE, EXPAND, READY.
REQ-011 IDLE: start=1 -> rk[0] <= key_in, cnt <= 1, go to EXPAND.
REQ-012 EXPAND: each cycle computes rk[cnt] from rk[cnt-1] and increments cnt; when cnt==10, writes rk[10] and goes to READY.
REQ-013 Round step: temp = SubWord(RotWord(w3)) ^ {Rcon[cnt],00,00,00}; w0'=w0^temp, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'; one round key per cycle.
REQ-014 Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
REQ-015 Latency: key_ready rises exactly 11 cycles after the edge that samples start; EXPAND lasts exactly 10 cycles.
REQ-016 busy = 1 in EXPAND only; key_ready = 1 in READY only; never both high.
REQ-017 start during EXPAND is ignored; the expansion in progress completes unchanged.
REQ-018 READY: start=1 behaves as in IDLE; key_ready drops on the next cycle and the stored keys are overwritten progressively.
REQ-019 key_in is sampled only at the start edge; later changes have no effect.
REQ-020 rd_key is a combinational read of rk[rd_round]; reads 0 for rd_round 11..15.
REQ-021 During EXPAND, rd_key for indices not yet written returns their previous contents; only data read while key_ready=1 is guaranteed valid.

Reset
REQ-022 rst has priority over all other inputs and applies in every state.
REQ-023 On rst: state=IDLE, cnt=0, busy=0, key_ready=0, and all rk[0..10] cleared to 0, so rd_key=0 for every index.
REQ-024 rst during EXPAND aborts the expansion; the block needs a fresh start afterwards.

Structure
REQ-025 Shared package aes_pkg holds: byte-array typedefs (byte_t, block_t[0:15]), NUM_ROUNDS=10, Rcon table, and the FSM state enum.
REQ-026 One sub-module, sbox: combinational 8-bit forward AES S-box, instantiated 4 times for SubWord.
REQ-027 Round-key storage is an 11 x 128-bit register array.
REQ-028 The design contains no multipliers and no latches.

Verification
REQ-029 FIPS-197 A.1: key 2b7e151628aed2a6abf7158809cf4f3c, start pulse -> key_ready after 11 cycles; rk1=a0fafe1788542cb123a339392a6c7605, rk10=d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-030 All-zero key -> rk1=62636363626363636263636362636363, rk10=b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-031 start held high for 5 cycles at cycle 3 of EXPAND, with key_in changed -> results equal the original key's; latency unchanged.
REQ-032 rst at cycle 6 of EXPAND -> next cycle busy=0, key_ready=0, rd_key=0 for rd_round 0..10; a new start then completes normally.
REQ-033 In READY, start with a second key -> key_ready low for exactly 11 cycles; then all rk match the second key's schedule.
REQ-034 rd_round=11..15 in READY -> rd_key=0.
